// File: rtl/motor_pkg.sv
// Shared types and constants for the motor soft-start/soft-stop ramp sequencer.
package motor_pkg;

  localparam int DUTY_W     = 4;
  localparam int PWM_PERIOD = 16;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    DOWN,
    HOLD,
    KICK
  } ramp_state_t;

endpackage

// File: rtl/ramp_step_timer.sv
// PWM-period phase counter plus the boundary counter that paces one-level duty steps.
module ramp_step_timer
  import motor_pkg::*;
#(
  parameter int STEP_PERIODS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic boundary,
  output logic step
);

  localparam int PH_W = $clog2(PWM_PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PWM_PERIOD - 1);
  localparam logic [7:0] CNT_LAST = 8'(STEP_PERIODS - 1);

  logic [PH_W-1:0] phase;
  logic [7:0]      step_cnt;

  assign boundary = (phase == PH_LAST);
  assign step     = run && !clr && boundary && (step_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= '0;
      step_cnt <= '0;
    end else begin
      phase <= phase + PH_W'(1);
      if (!run || clr) begin
        step_cnt <= '0;
      end else if (boundary) begin
        step_cnt <= (step_cnt == CNT_LAST) ? 8'd0 : step_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Soft-start/soft-stop duty sequencer for the motor PWM stage.
// Define MOTOR_RAMP_KICK_EN to add a full-duty breakaway kick when starting from IDLE.
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int STEP_PERIODS = 4,
  parameter int KICK_PERIODS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DUTY_W-1:0] target,
  input  logic              target_valid,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              at_target
);

  if (STEP_PERIODS < 1 || STEP_PERIODS > 255 || KICK_PERIODS < 1 || KICK_PERIODS > 255) begin : g_bad_param
    $error("motor_ramp_ctrl: STEP_PERIODS and KICK_PERIODS must be 1..255");
  end

  ramp_state_t       state, state_nxt, dir;
  logic [DUTY_W-1:0] target_reg, eff_target, duty_nxt, tgt_nxt;
  logic              boundary, step, run, clr;

  assign eff_target = enable ? target_reg : {DUTY_W{1'b0}};
  assign tgt_nxt    = target_valid ? target : target_reg;
  assign run        = (state == UP) || (state == DOWN);
  // Any disagreement between the registered state and the wanted direction restarts pacing.
  assign clr        = (dir != state);

  ramp_step_timer #(.STEP_PERIODS(STEP_PERIODS)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clr      (clr),
    .boundary (boundary),
    .step     (step)
  );

  always_comb begin
    if (duty < eff_target)       dir = UP;
    else if (duty > eff_target)  dir = DOWN;
    else if (eff_target == '0)   dir = IDLE;
    else                         dir = HOLD;
  end

`ifdef MOTOR_RAMP_KICK_EN
  localparam logic [7:0] KICK_LAST = 8'(KICK_PERIODS - 1);
  logic [7:0] kick_cnt, kick_cnt_nxt;
`endif

  always_comb begin
    state_nxt = dir;
    duty_nxt  = duty;
`ifdef MOTOR_RAMP_KICK_EN
    kick_cnt_nxt = kick_cnt;
`endif
    if (boundary && step) begin
      duty_nxt = (state == UP) ? duty + DUTY_W'(1) : duty - DUTY_W'(1);
    end
`ifdef MOTOR_RAMP_KICK_EN
    if (state == IDLE && dir == UP) begin
      state_nxt = KICK;
    end else if (state == KICK) begin
      if (eff_target == '0) begin
        state_nxt = DOWN;
      end else begin
        state_nxt = KICK;
        // First boundary raises to full duty; the count then spans whole periods.
        if (boundary) begin
          if (duty != '1) begin
            duty_nxt     = '1;
            kick_cnt_nxt = 8'd0;
          end else if (kick_cnt == KICK_LAST) begin
            duty_nxt  = DUTY_W'(1);
            state_nxt = UP;
          end else begin
            kick_cnt_nxt = kick_cnt + 8'd1;
          end
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      duty       <= '0;
      target_reg <= '0;
      busy       <= 1'b0;
      at_target  <= 1'b1;
`ifdef MOTOR_RAMP_KICK_EN
      kick_cnt   <= 8'd0;
`endif
    end else begin
      state      <= state_nxt;
      duty       <= duty_nxt;
      target_reg <= tgt_nxt;
      busy       <= (state_nxt == UP) || (state_nxt == DOWN) || (state_nxt == KICK);
      at_target  <= (duty_nxt == (enable ? tgt_nxt : {DUTY_W{1'b0}}));
`ifdef MOTOR_RAMP_KICK_EN
      kick_cnt   <= kick_cnt_nxt;
`endif
    end
  end

endmodule
